// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative RV32M multiply/divide unit.
//   muldiv_op_e    - funct3 encodings of the M-extension operations
//   muldiv_state_e - control FSM states
//   MULDIV_ITERS   - radix-2 iterations per operation
package muldiv_pkg;

  localparam int unsigned MULDIV_ITERS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one radix-2 step per cycle.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request, sampled only in IDLE
//   funct3          operation select (muldiv_op_e)
//   op_a, op_b      rs1 / rs2 values, sampled with start
//   rd_in           destination register, sampled with start
//   kill            flush; aborts any operation in flight
//   busy            high while not IDLE
//   wb_we           one-cycle write-back strobe (suppressed for x0)
//   wb_rd, wb_data  write-back address and data, held between results
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              kill,
  output logic              busy,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data
);

  localparam int unsigned CW = 6;
  localparam logic [CW-1:0]   LAST_ITER = CW'(MULDIV_ITERS - 1);
  localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e state, state_next;

  muldiv_op_e        op_q;
  logic [REG_AW-1:0] rd_q;
  logic [2*XLEN-1:0] acc_q;   // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opnd_q;  // mul: multiplicand magnitude; div: divisor magnitude
  logic              sign_a_q, sign_b_q;
  logic [CW-1:0]     cnt_q;

  // Request decode: signedness, magnitudes and the divide short path
  muldiv_op_e    op_in;
  logic          is_div_in, neg_a_in, neg_b_in, div_zero, div_ovf, short_in;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    op_in     = muldiv_op_e'(funct3);
    is_div_in = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    neg_a_in  = op_a[XLEN-1] && (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    neg_b_in  = op_b[XLEN-1] && (op_in inside {OP_MULH, OP_DIV, OP_REM});
    mag_a     = neg_a_in ? -op_a : op_a;
    mag_b     = neg_b_in ? -op_b : op_b;
    div_zero  = is_div_in && (op_b == '0);
    div_ovf   = (op_in inside {OP_DIV, OP_REM}) && (op_a == MIN_INT) && (op_b == '1);
    short_in  = div_zero || div_ovf;
  end

  // One iteration: shift-add for multiply, restoring step for divide
  logic              is_div;
  logic [XLEN:0]     mul_sum, div_trial;
  logic              div_ok;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    is_div    = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    div_ok    = ~div_trial[XLEN];
    if (is_div)
      acc_step = {(div_ok ? div_trial[XLEN-1:0] : acc_q[2*XLEN-2:XLEN-1]),
                  acc_q[XLEN-2:0], div_ok};
    else
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
  end

  // Sign correction and result selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, result;

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      OP_MUL:                       result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quot_fix;
      default:                      result = rem_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; kill overrides everything
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = short_in ? FIX : CALC;
      CALC: if (cnt_q == LAST_ITER) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  // Output/control decode, registered below
  logic busy_d, we_d, load_wb, accept;

  always_comb begin
    busy_d  = (state_next != IDLE);
    load_wb = (state == FIX) && (state_next == DONE);
    we_d    = load_wb && (rd_q != '0);
    accept  = (state == IDLE) && (state_next != IDLE);
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      rd_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      op_q  <= op_in;
      rd_q  <= rd_in;
      cnt_q <= '0;
      if (short_in) begin
        // Answer preloaded as {remainder, quotient}; no sign fix needed
        sign_a_q <= 1'b0;
        sign_b_q <= 1'b0;
        opnd_q   <= '0;
        acc_q    <= div_zero ? {op_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, MIN_INT};
      end else begin
        sign_a_q <= neg_a_in;
        sign_b_q <= neg_b_in;
        opnd_q   <= is_div_in ? mag_b : mag_a;
        acc_q    <= {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
      end
    end else if (state == CALC) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      busy  <= busy_d;
      wb_we <= we_d;
      if (load_wb) begin
        wb_rd   <= rd_q;
        wb_data <= result;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Each operation is launched in cycle 0 and busy/wb_we are checked every
// cycle up to the return to IDLE; results are hand-computed constants.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        kill;
  logic        busy;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .rd_in   (rd_in),
    .kill    (kill),
    .busy    (busy),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch in the current cycle and check through cycle lat+1 (back in IDLE)
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data, input int lat);
    logic exp_we;
    exp_we = (rd != 5'd0);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    step();
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    rd_in  = 5'($urandom);
    funct3 = 3'($urandom);
    for (int c = 1; c <= lat + 1; c++) begin
      if (c > 1) step();
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(c <= lat));
      chk($sformatf("%s wb_we c%0d", tag, c), 32'(wb_we), 32'((c == lat) && exp_we));
      if ((c == lat) && exp_we) begin
        chk({tag, " wb_rd"}, 32'(wb_rd), 32'(rd));
        chk({tag, " wb_data"}, wb_data, exp_data);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    funct3 = 3'd0;
    op_a   = 32'd0;
    op_b   = 32'd0;
    rd_in  = 5'd0;
    kill   = 1'b0;
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset wb_we", 32'(wb_we), 32'd0);
    chk("reset wb_rd", 32'(wb_rd), 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    #10;
    rst_n = 1'b1;
    step();

    // Normal path, back-to-back launches
    run_op("MUL 7*-3",       3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34);
    run_op("MULH min*min",   3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 34);
    run_op("MULHSU -1*max",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, 34);
    run_op("MULHU max*max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, 34);
    run_op("DIV -7/2",       3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 34);
    run_op("REM -7/2",       3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 34);
    run_op("DIVU 100/7",     3'b101, 32'd100,      32'd7,        5'd12, 32'd14,       34);
    run_op("REMU 100/7",     3'b111, 32'd100,      32'd7,        5'd13, 32'd2,        34);

    // Short path
    run_op("DIVU 5/0",       3'b101, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 2);
    run_op("REMU 5/0",       3'b111, 32'd5,        32'd0,        5'd15, 32'd5,        2);
    run_op("DIV ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 2);
    run_op("REM ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        2);

    // x0 destination: no strobe, FSM still returns to IDLE
    run_op("MUL rd0",        3'b000, 32'd3,        32'd4,        5'd0,  32'd12,       34);

    // kill together with start in IDLE drops the request
    start  = 1'b1;
    kill   = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd1;
    op_b   = 32'd1;
    rd_in  = 5'd3;
    step();
    start = 1'b0;
    kill  = 1'b0;
    chk("kill+start busy", 32'(busy), 32'd0);
    step();
    chk("kill+start wb_we", 32'(wb_we), 32'd0);

    // kill in cycle 10 of a DIV, then a new start in cycle 11
    start  = 1'b1;
    funct3 = 3'b100;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    rd_in  = 5'd20;
    step();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) step();
      chk($sformatf("kill run busy c%0d", c), 32'(busy), 32'd1);
      chk($sformatf("kill run wb_we c%0d", c), 32'(wb_we), 32'd0);
    end
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill busy c11", 32'(busy), 32'd0);
    chk("kill wb_we c11", 32'(wb_we), 32'd0);
    run_op("DIVU after kill", 3'b101, 32'd1000, 32'd3, 5'd9, 32'd333, 34);

    // Reset in cycle 20 of a MUL
    start  = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd6;
    op_b   = 32'd7;
    rd_in  = 5'd4;
    step();
    start = 1'b0;
    for (int c = 2; c <= 20; c++) step();
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset wb_we", 32'(wb_we), 32'd0);
    chk("mid reset wb_rd", 32'(wb_rd), 32'd0);
    chk("mid reset wb_data", wb_data, 32'd0);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      chk($sformatf("post reset wb_we %0d", c), 32'(wb_we), 32'd0);
      chk($sformatf("post reset busy %0d", c), 32'(busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
